// File: rtl/quad_gen_if.sv
// Command channel of the quadrature generator: one burst per valid/ready handshake.
interface quad_gen_if #(
  parameter int unsigned DIVBITS = 16
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [15:0]        cmd_steps;
  logic [DIVBITS-1:0] period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_gen.sv
// Quadrature A/B generator emitting bursts of edges with programmable spacing.
// Define QUAD_GEN_INDEX_EN to add a modulo-CPR index counter driving z.
module quad_gen #(
  parameter int unsigned CNTBITS = 32,
  parameter int unsigned DIVBITS = 16,
  parameter int unsigned CPR     = 4096
) (
  input  logic                      clk,
  input  logic                      resetn,
  quad_gen_if.slave                 cmd,
  input  logic                      abort,
  output logic                      a,
  output logic                      b,
  output logic                      z,
  output logic signed [CNTBITS-1:0] position,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                      state_q;
  logic                        cmd_ready_q, busy_q, done_q, dir_q;
  logic [DIVBITS-1:0]          period_q, timer_q, period_eff;
  logic [15:0]                 remain_q;
  logic [1:0]                  phase_q, phase_nxt;
  logic                        a_q, b_q;
  logic signed [CNTBITS-1:0]   position_q;
  logic                        emit;

  assign period_eff = (cmd.period == '0) ? DIVBITS'(1) : cmd.period;
  assign phase_nxt  = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
  // Abort takes priority over an edge due in the same cycle.
  assign emit = (state_q == StRun) && (remain_q != '0) && !abort && (timer_q == DIVBITS'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dir_q       <= 1'b0;
      period_q    <= '0;
      timer_q     <= '0;
      remain_q    <= '0;
      phase_q     <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      position_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_ready_q && cmd.cmd_valid) begin
            dir_q       <= cmd.cmd_dir;
            remain_q    <= cmd.cmd_steps;
            period_q    <= period_eff;
            timer_q     <= period_eff;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StRun;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StRun: begin
          // remain_q == 0 is the trailing cycle after the last edge (or abort).
          if (remain_q == '0) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (abort) begin
            remain_q <= '0;
          end else if (emit) begin
            timer_q    <= period_q;
            remain_q   <= remain_q - 16'd1;
            phase_q    <= phase_nxt;
            a_q        <= phase_nxt[1] ^ phase_nxt[0];
            b_q        <= phase_nxt[1];
            position_q <= position_q + (dir_q ? CNTBITS'(1) : {CNTBITS{1'b1}});
          end else begin
            timer_q <= timer_q - DIVBITS'(1);
          end
        end
        StFin: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef QUAD_GEN_INDEX_EN
  localparam int unsigned IdxBits = (CPR > 2) ? $clog2(CPR) : 1;

  logic [IdxBits-1:0] idx_q, idx_d;
  logic               z_q;

  always_comb begin
    idx_d = idx_q;
    if (emit) begin
      if (dir_q) begin
        idx_d = (idx_q == IdxBits'(CPR - 1)) ? '0 : idx_q + IdxBits'(1);
      end else begin
        idx_d = (idx_q == '0) ? IdxBits'(CPR - 1) : idx_q - IdxBits'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q <= '0;
      z_q   <= 1'b1;
    end else begin
      idx_q <= idx_d;
      z_q   <= (idx_d == '0);
    end
  end

  assign z = z_q;
`else
  assign z = 1'b0;
`endif

  assign cmd.cmd_ready = cmd_ready_q;
  assign a             = a_q;
  assign b             = b_q;
  assign position      = position_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: edge-schedule reference model checked every clock, plus fixed pins.
module tb_quad_gen;
  localparam int unsigned CNTBITS = 8;
  localparam int unsigned DIVBITS = 8;
  localparam int unsigned CPR     = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic abort = 1'b0;
  logic a, b, z, busy, done;
  logic signed [CNTBITS-1:0] position;

  quad_gen_if #(.DIVBITS(DIVBITS)) cmd ();

  quad_gen #(.CNTBITS(CNTBITS), .DIVBITS(DIVBITS), .CPR(CPR)) dut (
    .clk(clk), .resetn(resetn), .cmd(cmd), .abort(abort), .a(a), .b(b), .z(z),
    .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int wrapc(input int v);
    logic signed [CNTBITS-1:0] t;
    t = v[CNTBITS-1:0];
    return int'(t);
  endfunction

  // Reference model: a burst accepted at edge T with n steps and spacing p places
  // edges at T+k*p (k=1..n); done follows the last edge (or abort) by one clock.
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int  e_n = 0;
  int  pos_m = 0, ph_m = 0;
  int  t_acc = 0, p_m = 1, e_last = 0, d_m = 0;
  bit  act = 0, abrt = 0, dir_m = 0, rdy_m = 0, busy_m = 0, done_m = 0;

  always @(posedge clk) begin
    int exp_z;
    #1;
    e_n++;
    if (!resetn) begin
      pos_m = 0; ph_m = 0; act = 0; rdy_m = 0; busy_m = 0; done_m = 0;
    end else begin
      done_m = 0;
      if (act) begin
        if (e_n == d_m) begin
          done_m = 1; busy_m = 0;
        end else if (e_n == d_m + 1) begin
          act = 0; rdy_m = 1;
        end else if (!abrt && e_n > t_acc && e_n <= e_last) begin
          if (abort) begin
            abrt = 1; d_m = e_n + 1;
          end else if ((e_n - t_acc) % p_m == 0) begin
            pos_m += dir_m ? 1 : -1;
            ph_m = (ph_m + (dir_m ? 1 : 3)) % 4;
          end
        end
      end else if (rdy_m && cmd.cmd_valid) begin
        t_acc  = e_n;
        dir_m  = cmd.cmd_dir;
        p_m    = (cmd.period == 0) ? 1 : int'(cmd.period);
        e_last = t_acc + int'(cmd.cmd_steps) * p_m;
        d_m    = e_last + 1;
        abrt = 0; act = 1; rdy_m = 0; busy_m = 1;
      end else begin
        rdy_m = 1;
      end
    end
`ifdef QUAD_GEN_INDEX_EN
    exp_z = ((((pos_m % int'(CPR)) + int'(CPR)) % int'(CPR)) == 0) ? 1 : 0;
`else
    exp_z = 0;
`endif
    chk("ab", int'({a, b}), int'(ab_tab[ph_m]));
    chk("position", int'(position), wrapc(pos_m));
    chk("busy", int'(busy), int'(busy_m));
    chk("done", int'(done), int'(done_m));
    chk("cmd_ready", int'(cmd.cmd_ready), int'(rdy_m));
    chk("z", int'(z), exp_z);
  end

  task automatic wait_ready(input string tag);
    int guard = 0;
    @(negedge clk);
    while (!cmd.cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd.cmd_ready) chk({tag, "_timeout"}, 0, 1);
  endtask

  // ab_after > 0 pulses abort so that it is sampled ab_after clocks after accept.
  task automatic run_burst(input logic dir, input int steps, input int per, input int ab_after);
    wait_ready("accept");
    cmd.cmd_valid = 1'b1;
    cmd.cmd_dir   = dir;
    cmd.cmd_steps = 16'(steps);
    cmd.period    = DIVBITS'(per);
    @(posedge clk);
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    if (ab_after > 0) begin
      repeat (ab_after - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  initial begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_dir   = 1'b0;
    cmd.cmd_steps = '0;
    cmd.period    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd.cmd_ready), 0);
    chk("rst_pos", int'(position), 0);
`ifdef QUAD_GEN_INDEX_EN
    chk("rst_z", int'(z), 1);
`endif
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd.cmd_ready), 1);

    run_burst(1'b1, 8, 4, 0);
    wait_ready("b1");
    chk("b1_pos", int'(position), 8);
    chk("b1_model_pos", pos_m, 8);
    chk("b1_ab", int'({a, b}), 0);
`ifdef QUAD_GEN_INDEX_EN
    chk("b1_z", int'(z), 1);
`endif

    run_burst(1'b0, 3, 0, 0);
    wait_ready("b2");
    chk("b2_pos", int'(position), 5);
    chk("b2_ab", int'({a, b}), 2);
`ifdef QUAD_GEN_INDEX_EN
    chk("b2_z", int'(z), 0);
`endif

    run_burst(1'b1, 100, 2, 11);
    wait_ready("abort");
    chk("abort_pos", int'(position), 10);
    chk("abort_ab", int'({a, b}), 3);

    run_burst(1'b1, 10, 2, 0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("midrst_pos", int'(position), 0);
    chk("midrst_busy", int'(busy), 0);

    run_burst(1'b1, 127, 0, 0);
    wait_ready("ovf_a");
    chk("ovf_pos127", int'(position), 127);
    run_burst(1'b1, 1, 1, 0);
    wait_ready("ovf_b");
    chk("ovf_wrap", int'(position), -128);

    for (int i = 0; i < 30; i++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 3)), ab);
      if ($urandom_range(0, 4) == 0) begin
        wait_ready("idle_abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end

    wait_ready("final");
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
